// File: rtl/parking_slot_manager.sv
// Occupancy keeper for an 8-slot lot: owns the free-slot bitmap, commits
// entries and exits on sensor rising edges, and times the two barrier gates.
module parking_slot_manager #(
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry,
    input  logic [2:0] park_number,
    input  logic       exit,
    input  logic [2:0] exit_number,
    output logic [7:0] parking_capacity,
    output logic [3:0] free_count,
    output logic       full,
    output logic       empty,
    output logic       entry_gate,
    output logic       exit_gate,
    output logic       entry_reject,
    output logic       exit_error
);

    typedef enum logic [1:0] {E_IDLE, E_OPEN, E_HOLD} entry_state_t;
    typedef enum logic [1:0] {X_IDLE, X_OPEN, X_HOLD} exit_state_t;

    localparam logic [7:0] GATE_LOAD = 8'(GATE_CYCLES);

    logic [7:0]   cap_q, cap_d;
    logic         entry_prev_q, exit_prev_q;
    entry_state_t e_state_q;
    exit_state_t  x_state_q;
    logic [7:0]   e_cnt_q, x_cnt_q;
    logic         entry_gate_q, exit_gate_q;
    logic         entry_reject_q, exit_error_q;
    logic [3:0]   popcnt;
    logic         entry_edge, exit_edge;
    logic         entry_ok, exit_ok;
    logic         entry_commit, exit_commit;

    always_comb begin
        popcnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            popcnt = popcnt + {3'b000, cap_q[i]};
        end
    end

    assign entry_edge = entry & ~entry_prev_q;
    assign exit_edge  = exit  & ~exit_prev_q;

    // Legality is judged on the pre-update bitmap, so a same-cycle exit
    // cannot rescue an entry that arrives while the lot is full.
    assign entry_ok     = (popcnt != 4'd0) && cap_q[park_number];
    assign exit_ok      = !cap_q[exit_number];
    assign entry_commit = (e_state_q == E_IDLE) && entry_edge && entry_ok;
    assign exit_commit  = (x_state_q == X_IDLE) && exit_edge  && exit_ok;

    always_comb begin
        cap_d = cap_q;
        if (entry_commit) cap_d[park_number] = 1'b0;
        if (exit_commit)  cap_d[exit_number] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q        <= 8'hFF;
            entry_prev_q <= 1'b0;
            exit_prev_q  <= 1'b0;
        end else begin
            cap_q        <= cap_d;
            entry_prev_q <= entry;
            exit_prev_q  <= exit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_state_q      <= E_IDLE;
            e_cnt_q        <= 8'd0;
            entry_gate_q   <= 1'b0;
            entry_reject_q <= 1'b0;
        end else begin
            entry_reject_q <= 1'b0;
            case (e_state_q)
                E_IDLE: begin
                    if (entry_edge) begin
                        if (entry_ok) begin
                            e_state_q    <= E_OPEN;
                            e_cnt_q      <= GATE_LOAD;
                            entry_gate_q <= 1'b1;
                        end else begin
                            entry_reject_q <= 1'b1;
                        end
                    end
                end
                E_OPEN: begin
                    if (e_cnt_q <= 8'd1) begin
                        e_state_q    <= E_HOLD;
                        e_cnt_q      <= 8'd0;
                        entry_gate_q <= 1'b0;
                    end else begin
                        e_cnt_q <= e_cnt_q - 8'd1;
                    end
                end
                E_HOLD: begin
                    if (!entry) e_state_q <= E_IDLE;
                end
                default: e_state_q <= E_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_state_q    <= X_IDLE;
            x_cnt_q      <= 8'd0;
            exit_gate_q  <= 1'b0;
            exit_error_q <= 1'b0;
        end else begin
            exit_error_q <= 1'b0;
            case (x_state_q)
                X_IDLE: begin
                    if (exit_edge) begin
                        if (exit_ok) begin
                            x_state_q   <= X_OPEN;
                            x_cnt_q     <= GATE_LOAD;
                            exit_gate_q <= 1'b1;
                        end else begin
                            exit_error_q <= 1'b1;
                        end
                    end
                end
                X_OPEN: begin
                    if (x_cnt_q <= 8'd1) begin
                        x_state_q   <= X_HOLD;
                        x_cnt_q     <= 8'd0;
                        exit_gate_q <= 1'b0;
                    end else begin
                        x_cnt_q <= x_cnt_q - 8'd1;
                    end
                end
                X_HOLD: begin
                    if (!exit) x_state_q <= X_IDLE;
                end
                default: x_state_q <= X_IDLE;
            endcase
        end
    end

    assign parking_capacity = cap_q;
    assign free_count       = popcnt;
    assign full             = (popcnt == 4'd0);
    assign empty            = (popcnt == 4'd8);
    assign entry_gate       = entry_gate_q;
    assign exit_gate        = exit_gate_q;
    assign entry_reject     = entry_reject_q;
    assign exit_error       = exit_error_q;

endmodule

// File: tb/tb_parking_slot_manager.sv
// Directed bench for parking_slot_manager with hand-computed expectations.
module tb_parking_slot_manager;

    logic       clk = 1'b0;
    logic       rst;
    logic       entry;
    logic [2:0] park_number;
    logic       exit;
    logic [2:0] exit_number;
    logic [7:0] parking_capacity;
    logic [3:0] free_count;
    logic       full, empty, entry_gate, exit_gate, entry_reject, exit_error;

    int n_vec = 0;
    int n_bad = 0;

    parking_slot_manager #(.GATE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .entry(entry), .park_number(park_number),
        .exit(exit), .exit_number(exit_number),
        .parking_capacity(parking_capacity), .free_count(free_count),
        .full(full), .empty(empty), .entry_gate(entry_gate), .exit_gate(exit_gate),
        .entry_reject(entry_reject), .exit_error(exit_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_entry(input logic [2:0] p);
        entry = 1'b1; park_number = p;
        tick();
        entry = 1'b0;
        idle(6);
    endtask

    task automatic do_exit(input logic [2:0] p);
        exit = 1'b1; exit_number = p;
        tick();
        exit = 1'b0;
        idle(6);
    endtask

    initial begin
        rst = 1'b1; entry = 1'b0; exit = 1'b0; park_number = 3'd0; exit_number = 3'd0;
        idle(2);
        rst = 1'b0;
        idle(3);
        // 1: reset state
        check("rst_cap", parking_capacity, 8'hFF);
        check("rst_free", free_count, 4'd8);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_gates", {entry_gate, exit_gate}, 2'b00);

        // 2: single entry, gate timing, held sensor
        entry = 1'b1; park_number = 3'd0;
        tick();
        check("e0_cap", parking_capacity, 8'hFE);
        check("e0_free", free_count, 4'd7);
        check("e0_gate_c1", entry_gate, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("e0_gate_c%0d", i), entry_gate, 1'b1);
        end
        tick();
        check("e0_gate_closed", entry_gate, 1'b0);
        park_number = 3'd1;
        idle(3);
        check("e0_held_cap", parking_capacity, 8'hFE);
        check("e0_held_gate", entry_gate, 1'b0);
        entry = 1'b0;
        idle(2);

        // 3: fill the lot, then a refused ninth entry
        for (int p = 1; p < 8; p++) do_entry(3'(p));
        check("fill_cap", parking_capacity, 8'h00);
        check("fill_full", full, 1'b1);
        check("fill_free", free_count, 4'd0);
        entry = 1'b1; park_number = 3'd3;
        tick();
        check("rej_pulse", entry_reject, 1'b1);
        check("rej_cap", parking_capacity, 8'h00);
        check("rej_gate", entry_gate, 1'b0);
        entry = 1'b0;
        tick();
        check("rej_pulse_end", entry_reject, 1'b0);
        idle(2);

        // 4: full-lot entry with same-cycle exit is still refused; exit commits
        entry = 1'b1; park_number = 3'd3;
        exit = 1'b1; exit_number = 3'd5;
        tick();
        check("fx_reject", entry_reject, 1'b1);
        check("fx_cap", parking_capacity, 8'h20);
        check("fx_free", free_count, 4'd1);
        check("fx_gates", {entry_gate, exit_gate}, 2'b01);
        entry = 1'b0; exit = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("x5_gate_c%0d", i), exit_gate, 1'b1);
        end
        tick();
        check("x5_gate_closed", exit_gate, 1'b0);
        idle(2);
        exit = 1'b1; exit_number = 3'd5;
        tick();
        check("xerr_pulse", exit_error, 1'b1);
        check("xerr_cap", parking_capacity, 8'h20);
        check("xerr_gate", exit_gate, 1'b0);
        exit = 1'b0;
        tick();
        check("xerr_pulse_end", exit_error, 1'b0);
        idle(2);

        // 5: simultaneous entry and exit commits
        do_exit(3'd4);
        do_exit(3'd6);
        do_exit(3'd7);
        check("pre_sim_cap", parking_capacity, 8'hF0);
        entry = 1'b1; park_number = 3'd4;
        exit = 1'b1; exit_number = 3'd2;
        tick();
        check("sim_cap", parking_capacity, 8'hE4);
        check("sim_free", free_count, 4'd4);
        check("sim_gates", {entry_gate, exit_gate}, 2'b11);
        entry = 1'b0; exit = 1'b0;
        idle(6);
        check("sim_gates_closed", {entry_gate, exit_gate}, 2'b00);

        // 6: reset during an open entry gate
        rst = 1'b1; #2; rst = 1'b0;
        idle(2);
        entry = 1'b1; park_number = 3'd7;
        tick();
        check("r6_cap", parking_capacity, 8'h7F);
        check("r6_gate", entry_gate, 1'b1);
        tick();
        rst = 1'b1; entry = 1'b0;
        #1;
        check("r6_async_gate", entry_gate, 1'b0);
        check("r6_async_cap", parking_capacity, 8'hFF);
        tick();
        rst = 1'b0;
        tick();
        entry = 1'b1; park_number = 3'd0;
        tick();
        check("r6_after_cap", parking_capacity, 8'hFE);
        check("r6_after_gate", entry_gate, 1'b1);
        check("r6_after_empty", empty, 1'b0);
        entry = 1'b0;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
